// File: rtl/ieee80211_tx_sequencer.sv
// 802.11a transmit frame sequencer: emits one SIGNAL beat and the DATA field as 24-bit beats.
// Optional build macro TX_SEQ_IFS_EN inserts an IFS_CYCLES idle gap after every frame.
`timescale 1ns/1ps
module ieee80211_tx_sequencer #(
  parameter int WIDTH = 24
`ifdef TX_SEQ_IFS_EN
  , parameter int IFS_CYCLES = 16
`endif
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_rate,
  input  logic [11:0]      req_length,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [3:0]       m_axis_tuser,
  output logic             busy,
  output logic             err
);

  localparam logic [3:0] RATE_6M  = 4'b1101;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b0101;
  localparam logic [3:0] RATE_18M = 4'b0111;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1011;
  localparam logic [3:0] RATE_48M = 4'b0001;
  localparam logic [3:0] RATE_54M = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIGNAL,
    ST_DATA,
    ST_PAD
`ifdef TX_SEQ_IFS_EN
    , ST_GAP
`endif
  } state_t;

`ifdef TX_SEQ_IFS_EN
  localparam state_t ST_END = ST_GAP;
`else
  localparam state_t ST_END = ST_IDLE;
`endif

  function automatic logic f_rate_ok(input logic [3:0] rate);
    case (rate)
      RATE_6M, RATE_9M, RATE_12M, RATE_18M,
      RATE_24M, RATE_36M, RATE_48M, RATE_54M: f_rate_ok = 1'b1;
      default:                                f_rate_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] f_ndbps(input logic [3:0] rate);
    case (rate)
      RATE_9M:  f_ndbps = 8'd36;
      RATE_12M: f_ndbps = 8'd48;
      RATE_18M: f_ndbps = 8'd72;
      RATE_24M: f_ndbps = 8'd96;
      RATE_36M: f_ndbps = 8'd144;
      RATE_48M: f_ndbps = 8'd192;
      RATE_54M: f_ndbps = 8'd216;
      default:  f_ndbps = 8'd24;
    endcase
  endfunction

  function automatic logic [23:0] f_signal(input logic [3:0] rate, input logic [11:0] len);
    logic [16:0] f;
    f = {len, 1'b0, rate};
    return {6'd0, ^f, f};
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic             r_live;
  logic [3:0]       r_rate;
  logic [11:0]      r_len;
  logic [11:0]      r_cnt;
  logic [WIDTH-1:0] r_pack;
  logic [1:0]       r_pos;
  logic             r_zfill;
  logic [15:0]      r_bits;
  logic [7:0]       r_sym;
  logic [7:0]       r_ndbps;
  logic [WIDTH-1:0] r_tdata;
  logic             r_tvalid;
  logic             r_tlast;
  logic [3:0]       r_tuser;
  logic             r_err;
`ifdef TX_SEQ_IFS_EN
  logic [15:0]      r_gap;
`endif

  logic             w_req_hs;
  logic             w_req_ok;
  logic             w_mhs;
  logic             w_room;
  logic             w_take;
  logic             w_consume;
  logic [7:0]       w_byte;
  logic [11:0]      w_cnt_nx;
  logic             w_last_byte;
  logic [WIDTH-1:0] w_beat;
  logic             w_data_emit;
  logic             w_pad_emit;
  logic             w_emit;
  logic [7:0]       w_sum;
  logic [7:0]       w_sym_nx;
  logic [15:0]      w_bits_nx;
  logic [15:0]      w_need;
  logic             w_done;
  logic             w_final_hs;

  assign w_req_hs    = req_valid && req_ready;
  assign w_req_ok    = f_rate_ok(req_rate) && (req_length != 12'd0);
  assign w_mhs       = r_tvalid && m_axis_tready;
  assign w_room      = (r_state == ST_DATA) && !r_tvalid && (r_cnt != r_len);
  // After an early tlast the missing bytes are synthesized as zeros, one per cycle.
  assign w_take      = w_room && (r_zfill || s_axis_tvalid);
  assign w_consume   = w_room && !r_zfill && s_axis_tvalid;
  assign w_byte      = r_zfill ? 8'h00 : s_axis_tdata;
  assign w_cnt_nx    = r_cnt + 12'd1;
  assign w_last_byte = (w_cnt_nx == r_len);
  assign w_data_emit = w_take && ((r_pos == 2'd2) || w_last_byte);
  assign w_pad_emit  = (r_state == ST_PAD) && (!r_tvalid || (w_mhs && !r_tlast));
  assign w_emit      = w_data_emit || w_pad_emit;
  assign w_final_hs  = w_mhs && r_tlast && ((r_state == ST_DATA) || (r_state == ST_PAD));

  always_comb begin
    w_beat = r_pack;
    case (r_pos)
      2'd0:    w_beat[7:0]   = w_byte;
      2'd1:    w_beat[15:8]  = w_byte;
      default: w_beat[23:16] = w_byte;
    endcase
  end

  // Symbol phase wraps by a single subtraction: r_sym < N_DBPS and N_DBPS >= 24.
  assign w_sum     = r_sym + 8'd24;
  assign w_sym_nx  = (w_sum >= r_ndbps) ? (w_sum - r_ndbps) : w_sum;
  assign w_bits_nx = r_bits + 16'd24;
  assign w_need    = {1'b0, r_len, 3'b000} + 16'd22;
  assign w_done    = (w_bits_nx >= w_need) && (w_sym_nx == 8'd0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_req_hs && w_req_ok) w_next = ST_SIGNAL;
      ST_SIGNAL: if (w_mhs) w_next = ST_DATA;
      ST_DATA:   if (w_final_hs) w_next = ST_END;
                 else if (w_mhs && (r_cnt == r_len)) w_next = ST_PAD;
      ST_PAD:    if (w_final_hs) w_next = ST_END;
`ifdef TX_SEQ_IFS_EN
      ST_GAP:    if (r_gap == 16'd0) w_next = ST_IDLE;
`endif
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = r_live && (r_state == ST_IDLE);
    s_axis_tready = w_room && !r_zfill;
    busy          = (r_state != ST_IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_live   <= 1'b0;
      r_rate   <= 4'd0;
      r_len    <= 12'd0;
      r_cnt    <= 12'd0;
      r_pack   <= '0;
      r_pos    <= 2'd0;
      r_zfill  <= 1'b0;
      r_bits   <= 16'd0;
      r_sym    <= 8'd0;
      r_ndbps  <= 8'd24;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= 4'd0;
      r_err    <= 1'b0;
`ifdef TX_SEQ_IFS_EN
      r_gap    <= 16'd0;
`endif
    end else begin
      r_live <= 1'b1;
      r_err  <= 1'b0;
      if (w_mhs) r_tvalid <= 1'b0;

      if (w_req_hs) begin
        if (w_req_ok) begin
          r_rate   <= req_rate;
          r_len    <= req_length;
          r_ndbps  <= f_ndbps(req_rate);
          r_cnt    <= 12'd0;
          r_pack   <= '0;
          r_pos    <= 2'd2;
          r_zfill  <= 1'b0;
          r_bits   <= 16'd0;
          r_sym    <= 8'd0;
          r_tdata  <= f_signal(req_rate, req_length);
          r_tvalid <= 1'b1;
          r_tlast  <= 1'b1;
          r_tuser  <= RATE_6M;
        end else begin
          r_err <= 1'b1;
        end
      end

      if (w_take) begin
        r_cnt <= w_cnt_nx;
        if (w_data_emit) begin
          r_pack <= '0;
          r_pos  <= 2'd0;
        end else begin
          r_pack <= w_beat;
          r_pos  <= r_pos + 2'd1;
        end
      end

      if (w_consume) begin
        if (s_axis_tlast && !w_last_byte) begin
          r_err   <= 1'b1;
          r_zfill <= 1'b1;
        end else if (!s_axis_tlast && w_last_byte) begin
          r_err <= 1'b1;
        end
      end

      if (w_emit) begin
        r_tdata  <= w_data_emit ? w_beat : '0;
        r_tvalid <= 1'b1;
        r_tlast  <= w_done;
        r_tuser  <= r_rate;
        r_bits   <= w_bits_nx;
        r_sym    <= w_sym_nx;
      end

`ifdef TX_SEQ_IFS_EN
      if (w_final_hs)                r_gap <= 16'(IFS_CYCLES - 1);
      else if (r_state == ST_GAP)    r_gap <= r_gap - 16'd1;
`endif
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign err           = r_err;

endmodule

// File: tb/tb_ieee80211_tx_sequencer.sv
// Bench for ieee80211_tx_sequencer: random and directed frames checked against a bit-stream model.
`timescale 1ns/1ps
module tb_ieee80211_tx_sequencer;

  localparam logic [3:0] R6  = 4'hD;
  localparam logic [3:0] R9  = 4'hF;
  localparam logic [3:0] R12 = 4'h5;
  localparam logic [3:0] R54 = 4'h3;

  logic        aclk;
  logic        aresetn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_rate;
  logic [11:0] req_length;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [3:0]  m_axis_tuser;
  logic        busy;
  logic        err;

  int n_vec;
  int n_miss;

  logic [7:0]  pay[$];
  logic [23:0] got_d[$];
  logic [3:0]  got_u[$];
  logic        got_l[$];
  logic [23:0] exp_d[$];
  logic [3:0]  exp_u[$];
  logic        exp_l[$];

  ieee80211_tx_sequencer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rate      (req_rate),
    .req_length    (req_length),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy),
    .err           (err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [3:0] pick_rate(input int i);
    case (i)
      0: return 4'hD;
      1: return 4'hF;
      2: return 4'h5;
      3: return 4'h7;
      4: return 4'h9;
      5: return 4'hB;
      6: return 4'h1;
      default: return 4'h3;
    endcase
  endfunction

  function automatic int ndbps(input logic [3:0] r);
    case (r)
      4'hD: return 24;
      4'hF: return 36;
      4'h5: return 48;
      4'h7: return 72;
      4'h9: return 96;
      4'hB: return 144;
      4'h1: return 192;
      default: return 216;
    endcase
  endfunction

  // Expected PPDU: SIGNAL word, then the DATA bit stream (16 SERVICE zeros, payload, zeros)
  // cut into 24-bit words until the tail fits and a whole number of OFDM symbols is filled.
  function automatic void build_expected(input logic [3:0] rate, input int len, input int tlast_at);
    logic [11:0] l12;
    logic [23:0] w;
    logic [7:0]  b;
    int nd, nb, need, idx;
    exp_d.delete(); exp_u.delete(); exp_l.delete();
    l12 = 12'(len);
    w = 24'd0;
    w[3:0]  = rate;
    w[16:5] = l12;
    w[17]   = ($countones(rate) + $countones(l12)) % 2;
    exp_d.push_back(w); exp_u.push_back(R6); exp_l.push_back(1'b1);
    nd = ndbps(rate);
    need = 16 + 8 * len + 6;
    nb = 1;
    while (!((24 * nb >= need) && ((24 * nb) % nd == 0))) nb++;
    for (int i = 0; i < nb; i++) begin
      w = 24'd0;
      for (int k = 0; k < 3; k++) begin
        idx = 3 * i + k - 2;
        b = 8'h00;
        if (idx >= 0 && idx < len && !(tlast_at > 0 && tlast_at < len && idx >= tlast_at))
          b = pay[idx];
        w[8*k +: 8] = b;
      end
      exp_d.push_back(w); exp_u.push_back(rate); exp_l.push_back(i == nb - 1);
    end
  endfunction

  task automatic run_frame(input logic [3:0] rate, input int len, input int nsend, input int tlast_at,
                           input int mode, input int gap_pct, input int exp_errs, input string tag);
    int idx, errs, lasts, budget;
    bit req_hs, s_hs, stalled, done, keep;
    logic [23:0] hold_d;
    logic [3:0]  hold_u;
    logic        hold_l;
    got_d.delete(); got_u.delete(); got_l.delete();
    build_expected(rate, len, tlast_at);
    idx = 0; errs = 0; lasts = 0; budget = 300 + 30 * len;
    req_hs = 0; s_hs = 0; stalled = 0; done = 0;
    hold_d = '0; hold_u = '0; hold_l = 1'b0;
    req_rate = rate; req_length = 12'(len);
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge aclk);
      keep = s_axis_tvalid && !s_hs;
      if (s_hs) idx++;
      if (req_hs) req_valid = 1'b0;
      if (c == 0) req_valid = 1'b1;
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (c % 2 == 0);
        default: m_axis_tready = ($urandom_range(1) == 1);
      endcase
      if (idx < nsend) begin
        s_axis_tvalid = keep ? 1'b1 : (int'($urandom_range(99)) >= gap_pct);
        s_axis_tdata  = pay[idx];
        s_axis_tlast  = (idx + 1 == tlast_at);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      if (err) errs++;
      if (stalled) begin
        n_vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold_d || m_axis_tuser !== hold_u ||
            m_axis_tlast !== hold_l) begin
          n_miss++;
          $display("FAIL %s stall_stable got v=%b d=%h u=%h l=%b required v=1 d=%h u=%h l=%b",
                   tag, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, hold_d, hold_u, hold_l);
        end
      end
      req_hs = req_valid && req_ready;
      s_hs   = s_axis_tvalid && s_axis_tready;
      if (m_axis_tvalid && m_axis_tready) begin
        got_d.push_back(m_axis_tdata); got_u.push_back(m_axis_tuser); got_l.push_back(m_axis_tlast);
        if (got_d.size() == 2) begin
          n_vec++;
          if (busy !== 1'b1) begin
            n_miss++;
            $display("FAIL %s busy_mid got %b required 1", tag, busy);
          end
        end
        if (m_axis_tlast) lasts++;
        if (lasts == 2) done = 1;
        stalled = 0;
      end else if (m_axis_tvalid) begin
        stalled = 1; hold_d = m_axis_tdata; hold_u = m_axis_tuser; hold_l = m_axis_tlast;
      end else begin
        stalled = 0;
      end
    end
    req_valid = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    if (!done) begin
      n_vec++; n_miss++;
      $display("FAIL %s timeout got %0d beats required %0d", tag, got_d.size(), exp_d.size());
    end
    @(negedge aclk);
    if (err) errs++;
`ifndef TX_SEQ_IFS_EN
    n_vec++;
    if (busy !== 1'b0) begin
      n_miss++;
      $display("FAIL %s busy_after got %b required 0", tag, busy);
    end
`endif
    n_vec++;
    if (got_d.size() != exp_d.size()) begin
      n_miss++;
      $display("FAIL %s beat_count got %0d required %0d", tag, got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      n_vec++;
      if ({got_d[i], got_u[i], got_l[i]} !== {exp_d[i], exp_u[i], exp_l[i]}) begin
        n_miss++;
        $display("FAIL %s beat%0d got d=%h u=%h l=%b required d=%h u=%h l=%b", tag, i,
                 got_d[i], got_u[i], got_l[i], exp_d[i], exp_u[i], exp_l[i]);
      end
    end
    n_vec++;
    if (errs != exp_errs) begin
      n_miss++;
      $display("FAIL %s err_pulses got %0d required %0d", tag, errs, exp_errs);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_vec++;
    if ({req_ready, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, busy, err} !== 36'd0) begin
      n_miss++;
      $display("FAIL %s outputs_zero got rr=%b st=%b mv=%b md=%h ml=%b mu=%h busy=%b err=%b required all 0",
               tag, req_ready, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, busy, err);
    end
  endtask

  task automatic check_6m_literal(input string tag);
    n_vec++;
    if (got_d.size() != 3 || got_d[0] !== 24'h00002D || got_d[1] !== 24'hA50000 || got_d[2] !== 24'h000000) begin
      n_miss++;
      $display("FAIL %s literal_beats got n=%0d %h %h %h required n=3 00002d a50000 000000",
               tag, got_d.size(), got_d[0], got_d[1], got_d[2]);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check_idle_outputs("reset");
    aresetn = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 1'b0) begin
      n_miss++;
      $display("FAIL reset req_ready_at_release got %b required 0", req_ready);
    end
    @(negedge aclk);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL reset req_ready_after_one_cycle got %b required 1", req_ready);
    end
  endtask

  task automatic test_6m_one_byte();
    pay = '{8'hA5};
    run_frame(R6, 1, 1, 1, 0, 0, 0, "6m_1byte");
    check_6m_literal("6m_1byte");
  endtask

  task automatic test_9m_three_bytes();
    pay = '{8'h01, 8'h02, 8'h03};
    run_frame(R9, 3, 3, 3, 0, 0, 0, "9m_3bytes");
    n_vec++;
    if (got_d.size() != 4 || got_d[0] !== 24'h00006F || got_d[1] !== 24'h010000 ||
        got_d[2] !== 24'h000302 || got_d[3] !== 24'h000000) begin
      n_miss++;
      $display("FAIL 9m_3bytes literal_beats got n=%0d %h %h %h %h required n=4 00006f 010000 000302 000000",
               got_d.size(), got_d[0], got_d[1], got_d[2], got_d[3]);
    end
  endtask

  task automatic test_backpressure();
    pay = '{8'h01, 8'h02, 8'h03};
    run_frame(R9, 3, 3, 3, 1, 40, 0, "backpressure");
    pay = '{8'hA5};
    run_frame(R6, 1, 1, 1, 1, 50, 0, "backpressure_6m");
    check_6m_literal("backpressure_6m");
  endtask

  task automatic invalid_req(input logic [3:0] rate, input logic [11:0] len, input string tag);
    @(negedge aclk);
    req_rate = rate; req_length = len; req_valid = 1'b1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL %s req_ready_before got %b required 1", tag, req_ready);
    end
    @(negedge aclk);
    req_valid = 1'b0;
    n_vec++;
    if (err !== 1'b1 || req_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL %s err_pulse got err=%b rr=%b required err=1 rr=1", tag, err, req_ready);
    end
    repeat (3) begin
      @(negedge aclk);
      n_vec++;
      if ({m_axis_tvalid, busy, s_axis_tready, err, req_ready} !== 5'b00001) begin
        n_miss++;
        $display("FAIL %s stays_idle got mv=%b busy=%b st=%b err=%b rr=%b required 0 0 0 0 1",
                 tag, m_axis_tvalid, busy, s_axis_tready, err, req_ready);
      end
    end
  endtask

  task automatic test_invalid();
    invalid_req(4'b0000, 12'd5, "invalid_rate");
    invalid_req(R6, 12'd0, "invalid_len0");
    pay = '{8'hA5};
    run_frame(R6, 1, 1, 1, 0, 0, 0, "after_invalid");
  endtask

  task automatic test_early_tlast();
    pay.delete();
    repeat (4) pay.push_back(8'($urandom_range(255)));
    run_frame(R6, 4, 2, 2, 0, 20, 1, "early_tlast");
  endtask

  task automatic test_missing_tlast();
    pay.delete();
    repeat (3) pay.push_back(8'($urandom_range(255)));
    run_frame(R12, 3, 3, 0, 2, 20, 1, "missing_tlast");
  endtask

  task automatic test_back_to_back();
    int len;
    logic [3:0] rate;
    for (int f = 0; f < 12; f++) begin
      rate = pick_rate($urandom_range(7));
      len  = $urandom_range(1, 40);
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(255)));
      run_frame(rate, len, len, len, $urandom_range(2), $urandom_range(50), 0, "random");
    end
  endtask

  task automatic test_reset_mid_data();
    bit seen;
    @(negedge aclk);
    req_rate = R54; req_length = 12'd40; req_valid = 1'b1; m_axis_tready = 1'b1;
    @(negedge aclk);
    req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge aclk);
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'($urandom_range(255)); s_axis_tlast = 1'b0;
      if (s_axis_tready) seen = 1;
    end
    n_vec++;
    if (!seen) begin
      n_miss++;
      $display("FAIL reset_mid reach_data got tready=%b required 1", s_axis_tready);
    end
    repeat (4) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1 check_idle_outputs("reset_mid");
    s_axis_tvalid = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    pay = '{8'hA5};
    run_frame(R6, 1, 1, 1, 0, 0, 0, "after_reset");
    check_6m_literal("after_reset");
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    aresetn = 1'b0; req_valid = 1'b0; req_rate = 4'd0; req_length = 12'd0;
    s_axis_tdata = 8'd0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    test_reset();
    test_6m_one_byte();
    test_9m_three_bytes();
    test_backpressure();
    test_invalid();
    test_early_tlast();
    test_missing_tlast();
    test_back_to_back();
    test_reset_mid_data();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
